// File: rtl/net_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : net_rx_deserializer
// Description : Receive end of the inter-board serial link. Recovers 8-bit
//               characters (idle-high line, 1 start bit, 8 data bits LSB
//               first, 1 stop bit) and hands them to the CPU through a
//               level flag that is held until the CPU acknowledges.
// Ports       :
//   clk_clk        in   system clock, rising edge
//   reset_reset_n  in   asynchronous active-low reset
//   serial_in      in   raw serial line, asynchronous to clk_clk
//   read_ack       in   one-cycle strobe: character consumed
//   net_data_in    out  last accepted character
//   char_received  out  character waiting (held until read_ack)
//   overrun        out  sticky: character completed while one was waiting
//   framing_error  out  sticky: stop bit sampled low
//   busy           out  receiver is inside a frame
// Revision    : 1.0  initial release
// ============================================================================
module net_rx_deserializer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       serial_in,
    input  logic       read_ack,
    output logic [7:0] net_data_in,
    output logic       char_received,
    output logic       overrun,
    output logic       framing_error,
    output logic       busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Two-flop synchronizer; reset to the idle level so a reset does not
    // look like a start edge unless the line really is low.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= serial_in;
            rx_s    <= rx_meta;
        end
    end

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    // One-cycle pulse carrying the stop-bit sample into the output stage.
    // Splitting the decision from the FSM lets the FSM re-enter IDLE in the
    // middle of the stop bit, so an immediately following start edge is seen.
    logic             frame_done;
    logic             stop_bit;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            frame_done <= 1'b0;
            stop_bit   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // busy trails the state by one edge, so it falls together with
            // the output update of a finished frame.
            busy       <= (state != IDLE);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        bit_idx <= 3'd0;
                        // A line back high at mid start bit was only a glitch.
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        frame_done <= 1'b1;
                        stop_bit   <= rx_s;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // CPU-facing registers. The ack clears first; a frame completing on the
    // same edge then overrides, which gives an ack/stop collision a clean
    // load with no overrun.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            net_data_in   <= 8'h00;
            char_received <= 1'b0;
            overrun       <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (read_ack) begin
                char_received <= 1'b0;
                overrun       <= 1'b0;
                framing_error <= 1'b0;
            end
            if (frame_done) begin
                if (!stop_bit) begin
                    framing_error <= 1'b1;
                end else if (!char_received || read_ack) begin
                    net_data_in   <= shreg;
                    char_received <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_net_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_net_rx_deserializer
// Description : Directed self-checking bench for net_rx_deserializer at
//               CLKS_PER_BIT=16. Edge numbers are counted from the posedge
//               count taken at the negedge where a frame starts (E = base+3).
// Revision    : 1.0  initial release
// ============================================================================
module tb_net_rx_deserializer;

    logic       clk = 1'b0;
    logic       reset_reset_n;
    logic       serial_in;
    logic       read_ack;
    logic [7:0] net_data_in;
    logic       char_received;
    logic       overrun;
    logic       framing_error;
    logic       busy;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int base     = 0;

    net_rx_deserializer #(
        .CLKS_PER_BIT(16)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_reset_n),
        .serial_in     (serial_in),
        .read_ack      (read_ack),
        .net_data_in   (net_data_in),
        .char_received (char_received),
        .overrun       (overrun),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns 1 time unit after posedge number n.
    task automatic at_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller starts this at a negedge; each bit lasts 16 clocks.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            repeat (16) @(negedge clk);
        end
        serial_in = 1'b1;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        read_ack = 1'b1;
        @(negedge clk);
        read_ack = 1'b0;
    endtask

    initial begin
        reset_reset_n = 1'b0;
        serial_in     = 1'b1;
        read_ack      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", net_data_in, 8'h00);
        check("rst_cr", char_received, 0);
        check("rst_ovr", overrun, 0);
        check("rst_fe", framing_error, 0);
        check("rst_busy", busy, 0);
        reset_reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Start glitch: low for 4 clocks, start sample at E+8 sees high.
        base = cyc;
        serial_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_in = 1'b1;
        at_edge(base + 7);
        check("glitch_busy_mid", busy, 1);
        at_edge(base + 11);
        check("glitch_busy_e8", busy, 1);
        at_edge(base + 12);
        check("glitch_busy_e9", busy, 0);
        check("glitch_cr", char_received, 0);
        check("glitch_data", net_data_in, 8'h00);
        check("glitch_fe", framing_error, 0);
        repeat (20) @(negedge clk);

        // Single byte 0xA5.
        @(negedge clk);
        base = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                at_edge(base + 3);
                check("a5_busy_e", busy, 0);
                at_edge(base + 4);
                check("a5_busy_e1", busy, 1);
                at_edge(base + 155);
                check("a5_cr_e152", char_received, 0);
                check("a5_busy_e152", busy, 1);
                at_edge(base + 156);
                check("a5_cr_e153", char_received, 1);
                check("a5_data", net_data_in, 8'hA5);
                check("a5_busy_e153", busy, 0);
                check("a5_fe", framing_error, 0);
            end
        join
        pulse_ack();
        check("a5_ack_cr", char_received, 0);
        check("a5_ack_data", net_data_in, 8'hA5);

        // Framing error: 0x3C with stop bit low.
        @(negedge clk);
        base = cyc;
        fork
            send_frame(8'h3C, 1'b0);
            begin
                at_edge(base + 156);
                check("fe_flag", framing_error, 1);
                check("fe_cr", char_received, 0);
                check("fe_data", net_data_in, 8'hA5);
            end
        join
        repeat (4) @(negedge clk);
        pulse_ack();
        check("fe_ack", framing_error, 0);

        // Overrun: 0x11 then 0x22 back to back, no ack.
        @(negedge clk);
        base = cyc;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                at_edge(base + 156);
                check("ovr_first_cr", char_received, 1);
                check("ovr_first_data", net_data_in, 8'h11);
                check("ovr_first_ovr", overrun, 0);
                at_edge(base + 316);
                check("ovr_data", net_data_in, 8'h11);
                check("ovr_cr", char_received, 1);
                check("ovr_flag", overrun, 1);
            end
        join
        pulse_ack();
        check("ovr_ack_cr", char_received, 0);
        check("ovr_ack_ovr", overrun, 0);

        // Ack collides with the completion of the second character.
        @(negedge clk);
        base = cyc;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                at_edge(base + 156);
                check("col_first_data", net_data_in, 8'h11);
                at_edge(base + 315);
                read_ack = 1'b1;
                at_edge(base + 316);
                read_ack = 1'b0;
                check("col_data", net_data_in, 8'h22);
                check("col_cr", char_received, 1);
                check("col_ovr", overrun, 0);
            end
        join

        // Reset during data bit 3 of 0xFF, then a clean 0x5A.
        @(negedge clk);
        base = cyc;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                at_edge(base + 70);
                check("mid_busy_pre", busy, 1);
                @(negedge clk);
                reset_reset_n = 1'b0;
                #1;
                check("mid_rst_data", net_data_in, 8'h00);
                check("mid_rst_cr", char_received, 0);
                check("mid_rst_busy", busy, 0);
                check("mid_rst_ovr", overrun, 0);
                check("mid_rst_fe", framing_error, 0);
                repeat (5) @(negedge clk);
                reset_reset_n = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("mid_idle_busy", busy, 0);
        check("mid_idle_cr", char_received, 0);

        @(negedge clk);
        base = cyc;
        fork
            send_frame(8'h5A, 1'b1);
            begin
                at_edge(base + 156);
                check("5a_cr", char_received, 1);
                check("5a_data", net_data_in, 8'h5A);
                check("5a_fe", framing_error, 0);
                check("5a_ovr", overrun, 0);
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/net_rx_deserializer.md
# net_rx_deserializer

Receive end of the inter-board serial link. Recovers 8-bit characters from the incoming idle-high serial line (start bit, 8 data bits LSB first, stop bit) and presents each completed character to the Nios CPU. The CPU sees the character on its `net_data_in` PIO and a `char_received` flag on its `char_received` PIO, and acknowledges through a one-cycle `read_ack` strobe. This block mirrors the transmit path driven by `net_data_out`/`transmit_enable`/`load`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; must be even and ≥ 4.
- `HALF`, `CLKS_PER_BIT/2`: derived localparam, not overridable.
- `clk_clk`  in  1  system clock; all logic on rising edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `serial_in`  in  1  raw serial line, idle high, asynchronous to `clk_clk`.
- `read_ack`  in  1  one-cycle strobe from CPU: character consumed.
- `net_data_in`  out  8  last accepted character.
- `char_received`  out  1  character waiting; level, held until `read_ack`.
- `overrun`  out  1  sticky: a character completed while `char_received` was high.
- `framing_error`  out  1  sticky: stop bit sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `serial_in` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1.
- FSM states are IDLE, START, DATA and STOP. One counter `cnt` is cleared on every state entry. A 3-bit `bit_idx` counts data bits.
- **IDLE**: when `rx_s`==0, go to START.
- **START**: when `cnt`==HALF-1, sample `rx_s`.
  - If 1 (glitch), return to IDLE with no flag change.
  - If 0, go to DATA.
- **DATA**: when `cnt`==CLKS_PER_BIT-1, shift `rx_s` into bit `bit_idx` of the shift register (LSB first) and clear `cnt`.
  - After bit 7, go to STOP.
- **STOP**: when `cnt`==CLKS_PER_BIT-1, sample `rx_s` and return to IDLE.
  - If `rx_s`==0: set `framing_error`. The character is discarded; `net_data_in` and `char_received` are unchanged.
  - If `rx_s`==1 and `char_received`==0: load `net_data_in` and set `char_received`.
  - If `rx_s`==1 and `char_received`==1 (with no `read_ack` this cycle): set `overrun`. `net_data_in` keeps the old character and the new one is dropped.
- **`read_ack`**: clears `char_received`, `overrun` and `framing_error` on the next edge.
- **`read_ack` on the same edge as a good stop sample**: the new character loads, `char_received` stays 1, and `overrun` is not set.
- **`read_ack` while `char_received`==0**: clears the sticky flags only.
- **Reset (asynchronous, any time including mid-frame)**:
  - State goes to IDLE; `cnt`, `bit_idx` and the shift register go to 0.
  - Outputs `net_data_in`=0x00, `char_received`=0, `overrun`=0, `framing_error`=0, `busy`=0.
  - A partially received frame is lost.
  - After reset release, a line already low is treated as a start edge.

## Timing
- Synchronizer latency is 2 cycles from a `serial_in` transition to `rx_s`.
- Let edge E be the first clock edge at which IDLE sees `rx_s`==0.
  - Start sample: edge E + HALF.
  - Data bit k: edge E + HALF + (k+1)·CLKS_PER_BIT.
  - Stop sample: edge E + HALF + 9·CLKS_PER_BIT, i.e. E+152 at default.
- All outputs are registered. `char_received`, `net_data_in` and the error flags change on the edge following the stop sample.
- `busy` rises on E+1 and falls on the same edge at which `char_received` or `framing_error` updates.
- Back-to-back frames are supported: IDLE is re-entered mid-stop-bit, so a start edge immediately after the stop bit is detected.

## Test plan
- **Single byte**: 0xA5 framed at CLKS_PER_BIT=16 → `char_received` rises at E+153, `net_data_in`=0xA5, `busy` low from that edge. `read_ack` → `char_received`=0 next edge.
- **Start glitch**: `serial_in` low for 4 cycles, then high → FSM returns to IDLE at E+8. No flag changes; `net_data_in` stays 0x00.
- **Framing error**: 0x3C with stop bit 0 → `framing_error`=1, `char_received`=0, `net_data_in` unchanged. `read_ack` clears `framing_error`.
- **Overrun**: 0x11 then 0x22 back-to-back with no ack → `net_data_in`=0x11, `char_received`=1, `overrun`=1. `read_ack` clears both flags.
- **Ack collision**: 0x11 pending; `read_ack` coincides with the stop-sample edge of 0x22 → `net_data_in`=0x22, `char_received`=1, `overrun`=0.
- **Reset mid-frame**: assert `reset_reset_n`=0 during data bit 3 of 0xFF → all outputs 0 immediately. Release, then send 0x5A → received 0x5A with no error flags.
